button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000; number of consecutive stable cycles for a press or release to be accepted; SHALL be >= 1.
REQ-002 Parameter LONG_CYCLES, default 50000000; number of debounced-held cycles before the long-press event; SHALL be >= 1.
REQ-003 Parameter REPEAT_CYCLES, default 10000000; auto-repeat period after a long press; value 0 disables repeat.
REQ-004 Parameter ACTIVE_LOW, default 1; 1 means btn_in=0 is pressed, 0 means btn_in=1 is pressed.
REQ-005 Parameter CNT_W, default 26; counter width; SHALL hold max(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)-1.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 btn_in  input  1  button level, already synchronized to clk by an upstream two-flop synchronizer; no further synchronization here.
REQ-009 btn_level  output  1  debounced pressed level (1 = pressed).
REQ-010 press_pulse  output  1  one-cycle strobe on accepted press.
REQ-011 release_pulse  output  1  one-cycle strobe on accepted release.
REQ-012 long_pulse  output  1  one-cycle strobe when the long-press threshold is reached.
REQ-013 repeat_pulse  output  1  one-cycle strobe every REPEAT_CYCLES while long-held.

Function
REQ-014 pressed = btn_in XOR ACTIVE_LOW; all outputs SHALL be registered, with no combinational path from btn_in.
REQ-015 FSM states SHALL be IDLE, PRESS_WAIT, HELD, LONG, RELEASE_WAIT; a single counter cnt SHALL be cleared on every state change.
REQ-016 IDLE: btn_level=0; pressed -> PRESS_WAIT.
REQ-017 PRESS_WAIT: btn_level=0; not pressed -> IDLE; pressed and cnt==DEBOUNCE_CYCLES-1 -> HELD with press_pulse=1 and btn_level=1 registered on that edge; otherwise cnt+1.
REQ-018 Net press latency: press_pulse and btn_level rise on the edge sampling the (DEBOUNCE_CYCLES+1)th consecutive pressed value; any released sample before that restarts qualification.
REQ-019 HELD: btn_level=1; not pressed -> RELEASE_WAIT; pressed and cnt==LONG_CYCLES-1 -> LONG with long_pulse=1 and long_seen flag set; otherwise cnt+1.
REQ-020 LONG: btn_level=1; not pressed -> RELEASE_WAIT; REPEAT_CYCLES!=0 and cnt==REPEAT_CYCLES-1 -> repeat_pulse=1 and cnt=0, staying in LONG; otherwise cnt+1.
REQ-021 RELEASE_WAIT: btn_level held at 1; pressed -> LONG if long_seen else HELD (cnt cleared, so the long/repeat timing restarts), with no pulse; not pressed and cnt==DEBOUNCE_CYCLES-1 -> IDLE with release_pulse=1, btn_level=0, long_seen=0.
REQ-022 long_pulse SHALL fire at most once per accepted press, including across release bounces.
REQ-023 Each strobe SHALL be high for exactly one cycle; at most one strobe is high in any cycle.
REQ-024 Every accepted press SHALL be followed by exactly one release_pulse before the next press_pulse.

Reset
REQ-025 reset low SHALL immediately force state=IDLE, cnt=0, long_seen=0, and all outputs to 0, independent of clk.
REQ-026 After reset deasserts with the button already pressed, a full DEBOUNCE_CYCLES+1 qualification SHALL be required; no release_pulse SHALL be emitted for a press interrupted by reset.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=1; edge 0 = first edge sampling btn_in=0)
REQ-027 Clean press: btn_in=0 for edges 0..7, then 1 -> press_pulse high after edge 4 only; btn_level=1 from edge 4; release_pulse after edge 12; btn_level=0 from edge 12.
REQ-028 Glitch: btn_in=0 for 3 edges, then 1 -> all outputs stay 0.
REQ-029 Long hold: btn_in=0 continuously -> press_pulse at edge 4, long_pulse at edge 14, repeat_pulse at edges 17, 20, 23, ...; no other strobes.
REQ-030 Release bounce after long press: 2 released edges, then pressed again -> no release_pulse, btn_level stays 1, no second long_pulse, repeat_pulse resumes 3 edges after the re-press.
REQ-031 Reset mid-hold: reset low at edge 8 -> btn_level=0 asynchronously; with the button still held after deassert, press_pulse fires 4 edges after the first post-reset sample and no release_pulse occurs for the interrupted press.
REQ-032 Polarity: ACTIVE_LOW=0 with btn_in=1 for 5 edges -> press_pulse at edge 4.

Source files
------------

// File: rtl/button_debounce.sv
// Button debouncer with press, release, long-press and auto-repeat events.
// The input is assumed to be synchronized to clk already.
// One counter is shared by all states and restarts on every state change.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    LONG,
    RELEASE_WAIT
  } state_t;

  // Terminal counts. A disabled repeat period still gets a legal constant
  // so the comparison stays well-formed; it is never used in that case.
  localparam int              REP_LAST_I = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_LAST_I);
  localparam logic             REPEAT_EN = (REPEAT_CYCLES > 0);
  localparam logic             INVERT    = (ACTIVE_LOW != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             long_seen_q, long_seen_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             pressed;

  // Normalize polarity so the rest of the logic only deals with "pressed".
  assign pressed = btn_in ^ INVERT;

  // Next-state, counter and strobe decode; every output is then registered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    long_seen_d = long_seen_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pressed) begin
          state_d = PRESS_WAIT;
        end
      end

      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end

      HELD: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d     = LONG;
          cnt_d       = '0;
          long_d      = 1'b1;
          long_seen_d = 1'b1;
        end
      end

      LONG: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (!REPEAT_EN) begin
          cnt_d = cnt_q;
        end else if (cnt_q == REP_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end
      end

      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = long_seen_q ? LONG : HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          release_d   = 1'b1;
          long_seen_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        long_seen_d = 1'b0;
      end
    endcase

    level_d = (state_d == HELD) || (state_d == LONG) || (state_d == RELEASE_WAIT);
  end

  // State, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      long_seen_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_seen_q <= long_seen_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_debounce.sv
// Testbench for button_debounce: one active-low and one active-high instance
// see the same logical press pattern and are checked against a run-length
// reference model every cycle, plus directed timing spot checks.
module tb_button_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 10;
  localparam int REP  = 3;

  logic clk;
  logic reset;
  logic btnLow, btnHigh;
  logic lvlL, prL, rlL, lgL, rpL;
  logic lvlH, prH, rlH, lgH, rpH;
  logic [4:0] outLow, outHigh;

  int totalChecks;
  int passCount;
  int edgeIdx;
  int pressQ[$], relQ[$], longQ[$], repQ[$], hiPressQ[$];
  int levelZeroCount;

  // Reference model: debounced level flips after DEB+1 consecutive samples
  // that disagree with it; while pressed, age counts edges since the last
  // (re)entry and drives the long and repeat events.
  bit mLevel;
  int mDis;
  int mAge;
  bit mLongSeen;
  logic [4:0] mOut;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP),
    .ACTIVE_LOW(1), .CNT_W(8)
  ) dutLow (
    .clk(clk), .reset(reset), .btn_in(btnLow),
    .btn_level(lvlL), .press_pulse(prL), .release_pulse(rlL),
    .long_pulse(lgL), .repeat_pulse(rpL)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP),
    .ACTIVE_LOW(0), .CNT_W(8)
  ) dutHigh (
    .clk(clk), .reset(reset), .btn_in(btnHigh),
    .btn_level(lvlH), .press_pulse(prH), .release_pulse(rlH),
    .long_pulse(lgH), .repeat_pulse(rpH)
  );

  assign outLow  = {lvlL, prL, rlL, lgL, rpL};
  assign outHigh = {lvlH, prH, rlH, lgH, rpH};

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelReset();
    mLevel    = 1'b0;
    mDis      = 0;
    mAge      = 0;
    mLongSeen = 1'b0;
    mOut      = '0;
  endfunction

  function automatic void modelStep(input bit p);
    bit pr, rl, lg, rp;
    pr = 1'b0; rl = 1'b0; lg = 1'b0; rp = 1'b0;
    if (p != mLevel) begin
      mDis++;
      if (mDis == DEB + 1) begin
        mLevel = p;
        mDis   = 0;
        mAge   = 0;
        if (p) pr = 1'b1;
        else begin
          rl = 1'b1;
          mLongSeen = 1'b0;
        end
      end
    end else if (mLevel) begin
      if (mDis != 0) begin
        mDis = 0;
        mAge = 0;
      end else begin
        mAge++;
        if (!mLongSeen && mAge == LONG) begin
          lg = 1'b1;
          mLongSeen = 1'b1;
          mAge = 0;
        end else if (mLongSeen && REP != 0 && mAge == REP) begin
          rp = 1'b1;
          mAge = 0;
        end
      end
    end else begin
      mDis = 0;
    end
    mOut = {mLevel, pr, rl, lg, rp};
  endfunction

  task automatic checkVal(input string tag, input int obs, input int exp);
    totalChecks++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag);
    totalChecks++;
    assert (outLow === mOut) passCount++;
    else $error("FAIL %s active-low: observed %b expected %b (lvl,prs,rel,lng,rep) at edge %0d",
                tag, outLow, mOut, edgeIdx);
    totalChecks++;
    assert (outHigh === mOut) passCount++;
    else $error("FAIL %s active-high: observed %b expected %b (lvl,prs,rel,lng,rep) at edge %0d",
                tag, outHigh, mOut, edgeIdx);
  endtask

  task automatic clearLog();
    pressQ.delete(); relQ.delete(); longQ.delete(); repQ.delete(); hiPressQ.delete();
    levelZeroCount = 0;
    edgeIdx = 0;
  endtask

  // One clock edge with the given logical pressed value, then model and check.
  task automatic applyStimulus(input bit p, input string tag);
    btnLow  = ~p;
    btnHigh = p;
    @(posedge clk);
    if (!reset) modelReset();
    else modelStep(p);
    #1;
    checkOutput(tag);
    if (outLow[3]) pressQ.push_back(edgeIdx);
    if (outHigh[3]) hiPressQ.push_back(edgeIdx);
    if (outLow[2]) relQ.push_back(edgeIdx);
    if (outLow[1]) longQ.push_back(edgeIdx);
    if (outLow[0]) repQ.push_back(edgeIdx);
    if (!outLow[4]) levelZeroCount++;
    edgeIdx++;
  endtask

  task automatic doReset(input bit p);
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    applyStimulus(p, "in_reset");
    applyStimulus(p, "in_reset");
    reset = 1'b1;
  endtask

  function automatic int firstOf(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  initial begin
    int q[$];
    totalChecks = 0;
    passCount   = 0;
    reset   = 1'b0;
    btnLow  = 1'b1;
    btnHigh = 1'b0;
    clearLog();
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state");
    reset = 1'b1;
    $display("[TB] reset released");

    // Clean press: 8 pressed edges then released.
    clearLog();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, "clean_press");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, "clean_release");
    checkVal("clean_press_edge", firstOf(pressQ), 4);
    checkVal("clean_press_count", pressQ.size(), 1);
    checkVal("clean_release_edge", firstOf(relQ), 12);
    checkVal("polarity_press_edge", firstOf(hiPressQ), 4);
    checkVal("clean_level_low_edges", levelZeroCount, 8);

    // Glitch: 3 pressed edges never qualify.
    clearLog();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, "glitch");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, "glitch_idle");
    checkVal("glitch_pulses", pressQ.size() + relQ.size() + longQ.size() + repQ.size(), 0);
    checkVal("glitch_level", levelZeroCount, 11);

    // Long hold with repeats.
    clearLog();
    for (int i = 0; i < 25; i++) applyStimulus(1'b1, "long_hold");
    checkVal("long_press_edge", firstOf(pressQ), 4);
    checkVal("long_edge", firstOf(longQ), 14);
    checkVal("long_count", longQ.size(), 1);
    checkVal("repeat_count", repQ.size(), 3);
    q = repQ;
    checkVal("repeat_edge0", firstOf(q), 17);
    if (q.size() > 0) void'(q.pop_front());
    checkVal("repeat_edge1", firstOf(q), 20);
    if (q.size() > 0) void'(q.pop_front());
    checkVal("repeat_edge2", firstOf(q), 23);
    checkVal("long_release_count", relQ.size(), 0);
    doReset(1'b0);

    // Release bounce after long press.
    clearLog();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, "bounce_hold");
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, "bounce_gap");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, "bounce_repress");
    checkVal("bounce_release_count", relQ.size(), 0);
    checkVal("bounce_long_count", longQ.size(), 1);
    checkVal("bounce_repeat_edge", firstOf(repQ), 21);
    checkVal("bounce_level_low_edges", levelZeroCount, 4);
    doReset(1'b0);

    // Reset mid-hold with button still pressed afterwards.
    clearLog();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, "midhold");
    checkVal("midhold_level_before", int'(lvlL), 1);
    doReset(1'b1);
    checkVal("midhold_level_after_reset", int'(lvlL), 0);
    clearLog();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, "post_reset_hold");
    checkVal("post_reset_press_edge", firstOf(pressQ), 4);
    checkVal("post_reset_release_count", relQ.size(), 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, "post_reset_release");
    checkVal("post_reset_release_edge", firstOf(relQ), 12);

    // Randomized bursts of bounce, short and long holds, occasional reset.
    $display("[TB] random phase");
    for (int b = 0; b < 1500; b++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 24) : $urandom_range(1, 6);
      if ($urandom_range(0, 99) == 0) doReset(lvl);
      for (int i = 0; i < len; i++) applyStimulus(lvl, "random");
    end

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

  // Safety net so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: observed no completion, required completion");
    $fatal(1, "timeout");
  end

endmodule
